// File: rtl/rs_issue_select.sv
// Issue selector: picks one ready RS entry per cycle, pulses its clear and loads the issue/execute register.
// Define RS_ISSUE_RR_EN for round-robin arbitration; otherwise the lowest ready index wins.
module rs_issue_select #(
    parameter int RS_LEN = 8,
    parameter int IDX_W  = $clog2(RS_LEN),
    parameter int PKT_W  = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [RS_LEN-1:0]            ready,
    input  logic [RS_LEN-1:0][PKT_W-1:0] entry_packet,
    input  logic                         ex_stall,
    input  logic                         squash,
    output logic [RS_LEN-1:0]            clear,
    output logic [PKT_W-1:0]             is_ex_packet,
    output logic                         is_ex_valid,
    output logic [31:0]                  issue_count
);

    logic             can_issue;
    logic             found;
    logic             grant;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] grant_idx;

`ifdef RS_ISSUE_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    // RS_LEN is a power of two, so the IDX_W-bit add wraps RS_LEN-1 back to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= grant_idx + IDX_W'(1);
        end
    end

    assign base = rr_ptr;
`else
    assign base = '0;
`endif

    // Scan from base upward modulo RS_LEN; the first ready entry wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < RS_LEN; k++) begin
            cand = base + IDX_W'(k);
            if (!found && ready[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign can_issue = !squash && (!is_ex_valid || !ex_stall);
    assign grant     = can_issue && found;
    assign clear     = grant ? (RS_LEN'(1) << grant_idx) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            is_ex_valid  <= 1'b0;
            is_ex_packet <= '0;
        end else if (squash) begin
            is_ex_valid <= 1'b0;
        end else if (grant) begin
            is_ex_valid  <= 1'b1;
            is_ex_packet <= entry_packet[grant_idx];
        end else if (!(is_ex_valid && ex_stall)) begin
            is_ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_count <= '0;
        end else if (grant && (issue_count != 32'hFFFF_FFFF)) begin
            issue_count <= issue_count + 32'd1;
        end
    end

    // clear must be one-hot-or-zero and may only target an entry that is ready.
    a_clear_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(clear) && ((clear & ~ready) == '0));

endmodule

// File: tb/tb_rs_issue_select.sv
// Randomized and directed bench for rs_issue_select against a cycle-level behavioural model.
// Define RS_ISSUE_RR_EN here and in the DUT build to exercise round-robin arbitration.
module tb_rs_issue_select;

    logic             clock = 1'b0;
    logic             reset;
    logic [7:0]       ready;
    logic [7:0][63:0] entry_packet;
    logic             ex_stall;
    logic             squash;
    wire  [7:0]       clear;
    wire  [63:0]      is_ex_packet;
    wire              is_ex_valid;
    wire  [31:0]      issue_count;

    int checks = 0;
    int errors = 0;

    // Model state
    logic        m_valid;
    logic [63:0] m_pkt;
    logic [31:0] m_count;
    int          m_rr;
    int          exp_g;
    logic [7:0]  exp_clear;

    rs_issue_select #(.RS_LEN(8), .PKT_W(64)) dut (
        .clock(clock), .reset(reset), .ready(ready), .entry_packet(entry_packet),
        .ex_stall(ex_stall), .squash(squash), .clear(clear),
        .is_ex_packet(is_ex_packet), .is_ex_valid(is_ex_valid), .issue_count(issue_count)
    );

    always #5 clock = ~clock;

    // Which entry the selector should pick this cycle, or -1 for none.
    function automatic int model_grant(input logic [7:0] rdy, input logic st, input logic sq);
        int start;
        if (sq || (m_valid && st) || rdy == 8'h00) return -1;
`ifdef RS_ISSUE_RR_EN
        start = m_rr;
`else
        start = 0;
`endif
        for (int k = 0; k < 8; k++) begin
            if (rdy[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    // Called at a negedge: apply inputs and predict this cycle's clear.
    task automatic drive(input logic [7:0] rdy, input logic st, input logic sq);
        ready    = rdy;
        ex_stall = st;
        squash   = sq;
        for (int i = 0; i < 8; i++) entry_packet[i] = {$urandom, $urandom};
        exp_g     = model_grant(rdy, st, sq);
        exp_clear = (exp_g < 0) ? 8'h00 : (8'h01 << exp_g);
        #1;
    endtask

    // Advance one clock, updating the model with the inputs applied by drive.
    task automatic step();
        @(posedge clock);
        if (reset) begin
            m_valid = 1'b0;
            m_pkt   = '0;
            m_count = '0;
            m_rr    = 0;
        end else if (squash) begin
            m_valid = 1'b0;
        end else if (exp_g >= 0) begin
            m_valid = 1'b1;
            m_pkt   = entry_packet[exp_g];
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            m_rr    = (exp_g + 1) % 8;
        end else if (!(m_valid && ex_stall)) begin
            m_valid = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(8'h00, 1'b0, 1'b0);
            checks++;
            if (clear !== 8'h00) begin errors++; $display("FAIL reset_clear got %h exp 00", clear); end
            step();
            checks++;
            if (is_ex_valid !== 1'b0 || issue_count !== 32'd0 || is_ex_packet !== 64'd0) begin
                errors++;
                $display("FAIL reset_state got v=%b cnt=%0d pkt=%h exp v=0 cnt=0 pkt=0", is_ex_valid, issue_count, is_ex_packet);
            end
        end
    endtask

    task automatic test_pair();
        logic [63:0] p;
        drive(8'h14, 1'b0, 1'b0);
        p = entry_packet[2];
        checks++;
        if (clear !== 8'h04) begin errors++; $display("FAIL pair_clear0 got %h exp 04", clear); end
        step();
        checks++;
        if (is_ex_packet !== p || is_ex_valid !== 1'b1) begin errors++; $display("FAIL pair_pkt0 got %h/%b exp %h/1", is_ex_packet, is_ex_valid, p); end
        drive(8'h10, 1'b0, 1'b0);
        p = entry_packet[4];
        checks++;
        if (clear !== 8'h10) begin errors++; $display("FAIL pair_clear1 got %h exp 10", clear); end
        step();
        checks++;
        if (is_ex_packet !== p || is_ex_valid !== 1'b1) begin errors++; $display("FAIL pair_pkt1 got %h/%b exp %h/1", is_ex_packet, is_ex_valid, p); end
        checks++;
        if (issue_count !== 32'd2) begin errors++; $display("FAIL pair_count got %0d exp 2", issue_count); end
    endtask

    task automatic test_stall();
        logic [63:0] held;
        drive(8'hFF, 1'b0, 1'b0);
        step();
        held = m_pkt;
        for (int c = 0; c < 4; c++) begin
            drive(8'hFF, 1'b1, 1'b0);
            checks++;
            if (clear !== 8'h00) begin errors++; $display("FAIL stall_clear got %h exp 00", clear); end
            step();
            checks++;
            if (is_ex_packet !== held || is_ex_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%b exp %h/1", is_ex_packet, is_ex_valid, held); end
        end
        drive(8'hFF, 1'b0, 1'b0);
        checks++;
        if (clear === 8'h00 || clear !== exp_clear) begin errors++; $display("FAIL unstall_clear got %h exp %h", clear, exp_clear); end
        step();
        checks++;
        if (is_ex_packet !== m_pkt || is_ex_valid !== 1'b1) begin errors++; $display("FAIL unstall_pkt got %h/%b exp %h/1", is_ex_packet, is_ex_valid, m_pkt); end
    endtask

    task automatic test_stall_idle();
        drive(8'h00, 1'b0, 1'b0);
        step();
        drive(8'h08, 1'b1, 1'b0);
        checks++;
        if (clear !== 8'h08) begin errors++; $display("FAIL idle_stall_clear got %h exp 08", clear); end
        step();
        checks++;
        if (is_ex_valid !== 1'b1 || is_ex_packet !== m_pkt) begin errors++; $display("FAIL idle_stall_pkt got %h/%b exp %h/1", is_ex_packet, is_ex_valid, m_pkt); end
    endtask

    task automatic test_squash();
        logic [31:0] cnt;
        drive(8'h01, 1'b0, 1'b0);
        step();
        cnt = issue_count;
        drive(8'h01, 1'b0, 1'b1);
        checks++;
        if (clear !== 8'h00) begin errors++; $display("FAIL squash_clear got %h exp 00", clear); end
        step();
        checks++;
        if (is_ex_valid !== 1'b0 || issue_count !== m_count) begin errors++; $display("FAIL squash_state got v=%b cnt=%0d exp v=0 cnt=%0d", is_ex_valid, issue_count, m_count); end
        checks++;
        if (issue_count !== cnt) begin errors++; $display("FAIL squash_count got %0d exp %0d", issue_count, cnt); end
    endtask

    task automatic test_reset_mid_stall();
        drive(8'hFF, 1'b0, 1'b0);
        step();
        drive(8'hFF, 1'b1, 1'b0);
        step();
        reset = 1'b1;
        drive(8'hFF, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        checks++;
        if (is_ex_valid !== 1'b0 || issue_count !== 32'd0 || is_ex_packet !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_stall got v=%b cnt=%0d pkt=%h exp v=0 cnt=0 pkt=0", is_ex_valid, issue_count, is_ex_packet);
        end
    endtask

    task automatic test_arbitration();
        logic [7:0] want;
        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
`ifdef RS_ISSUE_RR_EN
            want = (c % 2 == 0) ? 8'h01 : 8'h80;
`else
            want = 8'h01;
`endif
            drive(8'h81, 1'b0, 1'b0);
            checks++;
            if (clear !== want) begin errors++; $display("FAIL arb_clear%0d got %h exp %h", c, clear, want); end
            step();
        end
    endtask

    task automatic test_saturate();
        force dut.issue_count = 32'hFFFF_FFFE;
        #1;
        release dut.issue_count;
        m_count = 32'hFFFF_FFFE;
        for (int c = 0; c < 3; c++) begin
            drive(8'hFF, 1'b0, 1'b0);
            step();
        end
        checks++;
        if (issue_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL saturate got %h exp ffffffff", issue_count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            checks++;
            if (clear !== exp_clear) begin errors++; $display("FAIL rand_clear c=%0d got %h exp %h", c, clear, exp_clear); end
            step();
            checks++;
            if (is_ex_valid !== m_valid || issue_count !== m_count || (m_valid && is_ex_packet !== m_pkt)) begin
                errors++;
                $display("FAIL rand_state c=%0d got v=%b cnt=%0d pkt=%h exp v=%b cnt=%0d pkt=%h",
                         c, is_ex_valid, issue_count, is_ex_packet, m_valid, m_count, m_pkt);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        ready        = '0;
        ex_stall     = 1'b0;
        squash       = 1'b0;
        entry_packet = '0;
        m_valid      = 1'b0;
        m_pkt        = '0;
        m_count      = '0;
        m_rr         = 0;
        exp_g        = -1;
        exp_clear    = '0;
        @(negedge clock);
        test_reset();
        test_pair();
        test_stall();
        test_stall_idle();
        test_squash();
        test_reset_mid_stall();
        test_arbitration();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_issue_select.md
# rs_issue_select

Issue-stage selector between the reservation-station entry array and the execute stage. Each cycle it picks one ready entry, pulses that entry's `clear`, and latches the entry's IS_PACKET into the issue/execute pipeline register. Stall back-pressure from execute and squash on mispredict are supported. It consumes the per-entry `ready` / `entry_packet` outputs and drives each entry's `clear` input.

## Interface
- `RS_LEN`, default 8: number of RS entries; power of two, ≥2.
- `IDX_W`, default `$clog2(RS_LEN)`: grant index width.
- `clock` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `ready` input RS_LEN: per-entry ready (busy and both tags zero).
- `entry_packet` input RS_LEN × IS_PACKET: per-entry held packet.
- `ex_stall` input 1: execute cannot accept the packet this cycle.
- `squash` input 1: flush; kills the in-flight issue and the output register.
- `clear` output RS_LEN: one-hot or zero combinational pulse to the granted entry.
- `is_ex_packet` output IS_PACKET: registered packet to execute.
- `is_ex_valid` output 1: `is_ex_packet` holds a live instruction.
- `issue_count` output 32: registered count of issued instructions, saturating at 2^32−1.

## Operation
- `can_issue` = !squash && (!is_ex_valid || !ex_stall).
- Grant: when `can_issue` and `ready` != 0, select one index g. Otherwise there is no grant and `clear` = 0.
- `clear[g]` = 1 only when a grant occurs, in the same cycle. All other `clear` bits are 0.
- Output register update, in priority order:
  - reset → `is_ex_valid` = 0, `is_ex_packet` = all-zero NOP packet (opa RS1, opb RS2, ALU_ADD, `NOP` inst, flags 0, valid 0).
  - squash → `is_ex_valid` = 0; packet contents don't-care.
  - grant → packet = `entry_packet[g]`, `is_ex_valid` = 1.
  - `is_ex_valid` && `ex_stall` → hold.
  - else → `is_ex_valid` = 0.
- `issue_count` increments by 1 on each grant and saturates. Reset value 0.
- Dispatch must not write an entry in the cycle its `clear` is high; the entry's `wr_en` would override `clear`. This is an RS-level invariant, checked by assertion.
- An entry's `ready` drops the cycle after `clear`, because `busy` falls. The selector therefore never re-grants the same instance.

## Timing
- Issue latency: an entry ready in cycle t, with `can_issue`, is cleared in cycle t. It is visible on `is_ex_packet` / `is_ex_valid` from cycle t+1.
- An entry that becomes ready at t+1 after dispatch at t, via CDB wakeup, issues at t+1 at the earliest.
- Throughput: 1 issue per cycle while `ex_stall` = 0.
- When `is_ex_valid` = 1 and `ex_stall` = 1: no grant and the packet is held stable. The first cycle `ex_stall` = 0, the current packet is consumed and a new grant may load in the same cycle (back-to-back).
- `ex_stall` while `is_ex_valid` = 0 has no effect; issue proceeds.
- Squash and grant in the same cycle: squash wins, no `clear`, `is_ex_valid` = 0 next cycle.
- Reset asserted mid-stall: all state returns to reset values next cycle.

## Configuration
- `RS_ISSUE_RR_EN` defined: round-robin arbitration.
  - Register `rr_ptr` [IDX_W], reset 0.
  - g is the first ready index scanning `rr_ptr`, `rr_ptr`+1, … modulo RS_LEN.
  - On grant, `rr_ptr` ← (g+1) mod RS_LEN, wrapping from RS_LEN−1 to 0. `rr_ptr` holds when there is no grant.
- Undefined: fixed priority. g is the lowest set index of `ready`. No pointer register exists.

## Test plan
- Reset, then `ready` = 0 for 3 cycles → `clear` = 0, `is_ex_valid` = 0, `issue_count` = 0.
- `ready` = 8'b0001_0100, no stall → cycle 0 `clear` = 8'b0000_0100. Cycle 1: `is_ex_packet` = `entry_packet[2]`, `clear` = 8'b0001_0000. Cycle 2: packet[4]. `issue_count` = 2.
- Hold `is_ex_valid` = 1 with `ex_stall` = 1 for 4 cycles, `ready` = 8'hFF → `clear` = 0 and packet unchanged throughout. First unstalled cycle grants and loads back-to-back.
- `squash` = 1 with `ready` = 8'h01 and `is_ex_valid` = 1 → `clear` = 0, `is_ex_valid` = 0 next cycle, counter unchanged.
- `RS_ISSUE_RR_EN`: hold `ready` = 8'h81 constant (entries re-dispatched) → grants alternate 0, 7, 0, 7. Without the macro → grant 0 every cycle.
- Force `issue_count` near max via 2^32−2 preload in sim, issue 3 → saturates at 32'hFFFF_FFFF.
